// File: rtl/logical_reduce_stream_if.sv
// Operand-frame input and reduced-result output channels of logical_reduce_stream.
// The slave modport is the reducer's view; the master modport is the producer/consumer side.
interface logical_reduce_stream_if #(
    parameter int N  = 8,
    parameter int CW = 5
);
    logic          s_valid;
    logic          s_ready;
    logic [N-1:0]  s_a;
    logic [N-1:0]  s_b;
    logic [1:0]    s_op;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic          m_c;
    logic [CW-1:0] m_count;
    logic          m_ovf;

    modport slave (
        input  s_valid, s_a, s_b, s_op, s_last, m_ready,
        output s_ready, m_valid, m_c, m_count, m_ovf
    );

    modport master (
        output s_valid, s_a, s_b, s_op, s_last, m_ready,
        input  s_ready, m_valid, m_c, m_count, m_ovf
    );
endinterface

// File: rtl/logical_reduce_stream.sv
// Reduces a frame of (a,b) operand beats to one OR/AND/XOR/NOR flag plus a saturating beat count.
// state | meaning
// IDLE  | waiting for the first beat of a frame; the operator is latched from it
// ACC   | accumulating further beats until the s_last beat
// HOLD  | result presented on m_*, frozen until m_ready
module logical_reduce_stream #(
    parameter int N         = 8,
    parameter int MAX_BEATS = 16,
    parameter int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    logical_reduce_stream_if.slave  s
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

    state_t        state_q, state_d;
    logic          alive_q;
    logic [1:0]    op_q, op_d, op_cur;
    logic          acc_q, acc_d, acc_base, acc_upd, beat_bit;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          mc_q, mc_d;
    logic [CW-1:0] mcount_q, mcount_d;
    logic          movf_q, movf_d;
    logic          pa, pb, beat;

    // alive_q keeps s_ready low until the first clock after reset release
    assign s.s_ready = alive_q && (state_q != HOLD);
    assign s.m_valid = (state_q == HOLD);
    assign s.m_c     = mc_q;
    assign s.m_count = mcount_q;
    assign s.m_ovf   = movf_q;

    assign beat = s.s_valid && s.s_ready;
    assign pa   = |s.s_a[N-1:0];
    assign pb   = |s.s_b[N-1:0];

    always_comb begin
        op_cur   = (state_q == IDLE) ? s.s_op : op_q;
        acc_base = (state_q == IDLE) ? (op_cur == OP_AND) : acc_q;
        case (op_cur)
            OP_AND:  begin beat_bit = pa & pb; acc_upd = acc_base & beat_bit; end
            OP_XOR:  begin beat_bit = pa ^ pb; acc_upd = acc_base ^ beat_bit; end
            default: begin beat_bit = pa | pb; acc_upd = acc_base | beat_bit; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mc_d     = mc_q;
        mcount_d = mcount_q;
        movf_d   = movf_q;
        case (state_q)
            IDLE, ACC: begin
                if (beat) begin
                    acc_d = acc_upd;
                    if (state_q == IDLE) begin
                        op_d  = s.s_op;
                        cnt_d = CW'(1);
                        ovf_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (s.s_last) begin
                        state_d  = HOLD;
                        // NOR is the OR accumulation inverted at frame end
                        mc_d     = (op_cur == 2'b11) ? ~acc_upd : acc_upd;
                        mcount_d = cnt_d;
                        movf_d   = ovf_d;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (s.m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            alive_q  <= 1'b0;
            op_q     <= OP_OR;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            mc_q     <= 1'b0;
            mcount_q <= '0;
            movf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            alive_q  <= 1'b1;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            mc_q     <= mc_d;
            mcount_q <= mcount_d;
            movf_q   <= movf_d;
        end
    end
endmodule
